// File: rtl/ram_loader.sv
// ram_loader: requests words from a source and writes them to consecutive memory addresses.
// Define RAM_LOADER_VERIFY_EN to read back and compare every written word (sticky error flag).
module ram_loader #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = 128,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic                  abort_i,
  output logic                  src_read_o,
  input  logic                  src_valid_i,
  input  logic [DATA_WIDTH-1:0] src_data_i,
  output logic [ADDR_WIDTH-1:0] mem_address_o,
  output logic [DATA_WIDTH-1:0] mem_data_o,
  output logic                  mem_write_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [ADDR_WIDTH:0]   count_o,
  output logic                  error_o
);

`ifdef RAM_LOADER_VERIFY_EN
  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WAIT, S_WRITE, S_VRD, S_VCMP, S_DONE
  } state_e;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WAIT, S_WRITE, S_DONE
  } state_e;
`endif

  localparam logic [ADDR_WIDTH:0]   DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] BASE_C  = ADDR_WIDTH'(BASE_ADDR);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [ADDR_WIDTH:0]   count_inc;
  logic [ADDR_WIDTH-1:0] wr_addr;

  assign count_inc = count_q + (ADDR_WIDTH+1)'(1);
  assign wr_addr   = BASE_C + count_q[ADDR_WIDTH-1:0];

`ifdef RAM_LOADER_VERIFY_EN
  logic                  error_q, error_d;
  logic [ADDR_WIDTH-1:0] rd_addr;

  // count has already advanced past the word being checked
  assign rd_addr = wr_addr - ADDR_WIDTH'(1);
  assign error_o = error_q;
`else
  logic unused_rdata;

  assign unused_rdata = ^mem_rdata_i;
  assign error_o      = 1'b0;
`endif

  assign count_o    = count_q;
  assign mem_data_o = data_q;

  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    data_d        = data_q;
    src_read_o    = 1'b0;
    mem_write_o   = 1'b0;
    mem_address_o = '0;
    done_o        = 1'b0;
    busy_o        = (state_q != S_IDLE);
`ifdef RAM_LOADER_VERIFY_EN
    error_d       = error_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          count_d = '0;
`ifdef RAM_LOADER_VERIFY_EN
          error_d = 1'b0;
`endif
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        src_read_o = 1'b1;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        if (src_valid_i) begin
          data_d  = src_data_i;
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        mem_write_o   = 1'b1;
        mem_address_o = wr_addr;
        count_d       = count_inc;
`ifdef RAM_LOADER_VERIFY_EN
        state_d       = S_VRD;
`else
        state_d       = (count_inc == DEPTH_C) ? S_DONE : S_REQ;
`endif
      end
`ifdef RAM_LOADER_VERIFY_EN
      S_VRD: begin
        mem_address_o = rd_addr;
        state_d       = S_VCMP;
      end
      S_VCMP: begin
        mem_address_o = rd_addr;
        if (mem_rdata_i != data_q) error_d = 1'b1;
        state_d = (count_q == DEPTH_C) ? S_DONE : S_REQ;
      end
`endif
      S_DONE: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // abort wins over everything, but a write strobe already on the bus still counts
    if (abort_i) begin
      state_d = S_IDLE;
      data_d  = data_q;
      if (state_q != S_WRITE) count_d = count_q;
`ifdef RAM_LOADER_VERIFY_EN
      error_d = error_q;
`endif
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      count_q <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      data_q  <= data_d;
    end
  end

`ifdef RAM_LOADER_VERIFY_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) error_q <= 1'b0;
    else         error_q <= error_d;
  end
`endif

endmodule

// File: doc/ram_loader.md
# ram_loader

Sequencing block that moves a programme or data image from a word source (the file reader in simulation, a ROM or serial front end in silicon) into the processor's data memory. It is the parametrised successor to hand-driven read/write pulsing: it issues read requests to the source, accepts words through a valid handshake, and writes them to consecutive addresses. Width, depth, base address and source latency are all parameters. A compile-time option reads back every word after it is written and checks it.

## Interface
- DATA_WIDTH, 8: word width of source and memory.
- ADDR_WIDTH, 8: memory address width.
- DEPTH, 128: number of words loaded per run. Legal range: 1 to 2^ADDR_WIDTH − BASE_ADDR.
- BASE_ADDR, 0: address of the first word.
- clock, input, 1: single clock, rising edge.
- reset, input, 1: asynchronous, active-low (0 = reset).
- start, input, 1: level sampled in IDLE; begins a load run.
- abort, input, 1: terminates a run. Takes priority over every other input.
- src_read, output, 1: one-cycle read request to the source.
- src_valid, input, 1: source word present on src_data. Ignored outside WAIT.
- src_data, input, DATA_WIDTH: source word.
- mem_address, output, ADDR_WIDTH: memory address.
- mem_data, output, DATA_WIDTH: write data, a registered copy of the captured word.
- mem_write, output, 1: one-cycle write strobe.
- mem_rdata, input, DATA_WIDTH: memory read data, synchronous with 1-cycle latency. Used only with RAM_LOADER_VERIFY_EN.
- busy, output, 1: high in every state except IDLE.
- done, output, 1: one-cycle pulse when a run completes normally.
- count, output, ADDR_WIDTH+1: number of words written in the current or last run.
- error, output, 1: sticky mismatch flag (verify builds only; tied 0 otherwise).

## Operation
- States: IDLE, REQ, WAIT, WRITE, VRD, VCMP, DONE. VRD and VCMP exist only with verify.
- IDLE:
  - If start = 1: count ← 0, error ← 0, go to REQ.
  - start is ignored in every other state.
- REQ: src_read = 1 for exactly this cycle, then go to WAIT.
- WAIT:
  - Stay until src_valid = 1.
  - On that cycle, capture src_data into the data register and go to WRITE.
  - No timeout.
- WRITE:
  - mem_write = 1, mem_address = BASE_ADDR + count, mem_data = captured word.
  - count increments at the end of this cycle.
  - Next state: VRD if verify is enabled. Otherwise DONE if the new count = DEPTH, else REQ.
- VRD: mem_write = 0, mem_address held at the address just written.
- VCMP:
  - Compare mem_rdata with the captured word.
  - On mismatch, set error. error stays set until the next start or reset.
  - Next state: DONE if count = DEPTH, else REQ.
- DONE: done = 1 for one cycle, then go to IDLE. count holds its final value.
- abort:
  - In any state, abort = 1 forces IDLE on the next edge.
  - No done pulse. A write strobe in the same cycle as abort still completes.
  - count retains the words written so far.
- Address arithmetic: BASE_ADDR + count, truncated to ADDR_WIDTH. A legal DEPTH never wraps.
- Reset values: all outputs 0, state IDLE, data register 0.

## Timing
- Source latency: src_valid may rise the cycle after src_read at the earliest, with unbounded latency after that.
- src_valid arriving during REQ is not captured.
- Best-case cycles per word: 3 (REQ, WAIT, WRITE), or 5 with verify.
- Total run length, zero wait states: 3·DEPTH + 1 cycles from the first REQ to the DONE pulse.
- src_read and mem_write are never high in the same cycle.
- A src_valid pulse held for multiple cycles is consumed once. The extra cycles are ignored because the FSM has already left WAIT.
- reset asserted mid-run: outputs clear immediately (asynchronously). The memory write in flight is lost.
- start held high continuously restarts a new run from the DONE→IDLE cycle onward: one idle cycle between runs.

## Configuration
- RAM_LOADER_VERIFY_EN defined: VRD/VCMP states are compiled in, mem_rdata is used, and error is live.
- Not defined: those states are absent, mem_rdata is unused, error is constant 0, and a word costs 3 cycles.

## Test plan
- Reset, then start with DEPTH=128, BASE_ADDR=0, and a source answering 1 cycle after each request with data = address XOR 8'hA5. Require: 128 writes to addresses 0x00–0x7F with matching data, done pulse after 385 cycles, count = 128.
- Source with random latency of 1–7 cycles per word, DEPTH=4, BASE_ADDR=8'hF0. Require: writes at 0xF0–0xF3, exactly 4 src_read pulses, no write before its src_valid.
- abort asserted while in WAIT for word 5. Require: IDLE next cycle, no done pulse, count = 5, no further src_read.
- reset driven low during WRITE of word 2. Require: mem_write, busy and count all 0 in the same cycle, asynchronously.
- start pulsed while busy. Require: no effect on count or address sequence.
- Verify build with the memory model corrupting address 3 (bit 0 flipped). Require: error = 1 after the VCMP for word 3, load still completes, done pulses, error clears on the next start.
